// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared text-mode geometry, control codes and writer state types
package ppu_pkg;

   localparam int TEXTCOL  = 64;
   localparam int TEXTROW  = 37;
   localparam int ADDRW    = 12;
   localparam int BUFFSIZE = TEXTCOL * TEXTROW;
   localparam int COLW     = 6;
   localparam int ROWW     = 6;

   localparam logic [7:0] FILL  = 8'h20;
   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_FF = 8'h0C;
   localparam logic [7:0] CC_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_SCROLL_CP,
      ST_SCROLL_CLR
   } tw_state_t;

   typedef enum logic [2:0] {
      CUR_HOLD,
      CUR_ADV,
      CUR_NL,
      CUR_CR,
      CUR_BS,
      CUR_HOME,
      CUR_LAST
   } cur_op_t;

   function automatic logic [ADDRW-1:0] cell_addr(input logic [COLW-1:0] col,
                                                  input logic [ROWW-1:0] row);
      return ADDRW'(row) * ADDRW'(TEXTCOL) + ADDRW'(col);
   endfunction

endpackage

// File: rtl/text_term_writer_if.sv
// rtl/text_term_writer_if.sv - byte input, video memory port and status of the text writer
interface text_term_writer_if;

   logic                        in_valid;
   logic [7:0]                  in_data;
   logic                        in_ready;
   logic                        vm_we;
   logic [ppu_pkg::ADDRW-1:0]   vm_waddr;
   logic [7:0]                  vm_wdata;
   logic [ppu_pkg::ADDRW-1:0]   vm_raddr;
   logic [7:0]                  vm_rdata;
   logic [ppu_pkg::COLW-1:0]    cur_col;
   logic [ppu_pkg::ROWW-1:0]    cur_row;
   logic                        busy;

   modport master (
      output in_valid, in_data, vm_rdata,
      input  in_ready, vm_we, vm_waddr, vm_wdata, vm_raddr, cur_col, cur_row, busy
   );

   modport slave (
      input  in_valid, in_data, vm_rdata,
      output in_ready, vm_we, vm_waddr, vm_wdata, vm_raddr, cur_col, cur_row, busy
   );

endinterface

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - cursor position register with advance/newline/backspace/home operations
module text_cursor
   import ppu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  cur_op_t          op_i,
   output logic [COLW-1:0]  col_o,
   output logic [ROWW-1:0]  row_o,
   output logic [ADDRW-1:0] addr_o,
   output logic [ADDRW-1:0] bs_addr_o,
   output logic             home_o,
   output logic             wrap_o
);

   localparam logic [COLW-1:0] LAST_COL = COLW'(TEXTCOL - 1);
   localparam logic [ROWW-1:0] LAST_ROW = ROWW'(TEXTROW - 1);

   logic [COLW-1:0] col_q, col_d, bs_col;
   logic [ROWW-1:0] row_q, row_d, bs_row;
   logic            last_col, last_row;

   assign last_col = (col_q == LAST_COL);
   assign last_row = (row_q == LAST_ROW);

   // Cell that a backspace lands on; meaningless at (0,0), where home_o gates its use.
   always_comb begin
      bs_col = col_q - 1'b1;
      bs_row = row_q;
      if (col_q == '0) begin
         bs_col = LAST_COL;
         bs_row = row_q - 1'b1;
      end
   end

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      wrap_o = 1'b0;
      case (op_i)
         CUR_ADV: begin
            if (last_col) begin
               col_d = '0;
               if (last_row) wrap_o = 1'b1;
               else          row_d  = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         CUR_NL: begin
            col_d = '0;
            if (last_row) wrap_o = 1'b1;
            else          row_d  = row_q + 1'b1;
         end
         CUR_CR:   col_d = '0;
         CUR_BS: begin
            if (!home_o) begin
               col_d = bs_col;
               row_d = bs_row;
            end
         end
         CUR_HOME: begin
            col_d = '0;
            row_d = '0;
         end
         CUR_LAST: begin
            col_d = '0;
            row_d = LAST_ROW;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign home_o    = (col_q == '0) && (row_q == '0);
   assign col_o     = col_q;
   assign row_o     = row_q;
   assign addr_o    = cell_addr(col_q, row_q);
   assign bs_addr_o = cell_addr(bs_col, bs_row);

endmodule

// File: rtl/text_term_writer.sv
// rtl/text_term_writer.sv - byte stream to text video memory writer with clear and scroll
module text_term_writer
   import ppu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   text_term_writer_if.slave  bus
);

   localparam logic [ADDRW-1:0] LAST_CELL = ADDRW'(BUFFSIZE - 1);
   localparam logic [ADDRW-1:0] LAST_ROW0 = ADDRW'((TEXTROW - 1) * TEXTCOL);

   tw_state_t        state_q, state_d;
   logic [ADDRW-1:0] ptr_q, ptr_d;
   logic             we_q, we_d;
   logic [ADDRW-1:0] waddr_q, waddr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [ADDRW-1:0] raddr_q, raddr_d;
   logic             rd_q, rd_d;
   logic             rd_data_q;
   logic [ADDRW-1:0] rd_addr_q;
   logic             in_ready_q, in_ready_d;
   logic             busy_q;

   cur_op_t          cur_op;
   logic [COLW-1:0]  cur_col;
   logic [ROWW-1:0]  cur_row;
   logic [ADDRW-1:0] cur_addr, bs_addr;
   logic             cur_home, cur_wrap;
   logic             accept, printable;

   assign accept    = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
   assign printable = (bus.in_data >= 8'h20);

   text_cursor u_cursor (
      .clk       (clk),
      .rst       (rst),
      .op_i      (cur_op),
      .col_o     (cur_col),
      .row_o     (cur_row),
      .addr_o    (cur_addr),
      .bs_addr_o (bs_addr),
      .home_o    (cur_home),
      .wrap_o    (cur_wrap)
   );

   // Cursor command is decoded on its own so the wrap flag can feed the FSM without a loop.
   always_comb begin
      cur_op = CUR_HOLD;
      if (accept) begin
         if (printable) cur_op = CUR_ADV;
         else if (bus.in_data == CC_CR) cur_op = CUR_CR;
         else if (bus.in_data == CC_LF) cur_op = CUR_NL;
         else if (bus.in_data == CC_BS) cur_op = CUR_BS;
      end else if (state_q == ST_CLEAR && ptr_q == LAST_CELL) begin
         cur_op = CUR_HOME;
      end else if (state_q == ST_SCROLL_CLR && ptr_q == LAST_CELL) begin
         cur_op = CUR_LAST;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      raddr_d = raddr_q;
      rd_d    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = FILL;
            if (ptr_q == LAST_CELL) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               if (printable) begin
                  we_d    = 1'b1;
                  waddr_d = cur_addr;
                  wdata_d = bus.in_data;
               end else if (bus.in_data == CC_BS && !cur_home) begin
                  we_d    = 1'b1;
                  waddr_d = bs_addr;
                  wdata_d = FILL;
               end else if (bus.in_data == CC_FF) begin
                  state_d = ST_CLEAR;
                  ptr_d   = '0;
               end
               if (cur_wrap) begin
                  state_d = ST_SCROLL_CP;
                  raddr_d = ADDRW'(TEXTCOL);
                  rd_d    = 1'b1;
                  ptr_d   = ADDRW'(TEXTCOL + 1);
               end
            end
         end
         ST_SCROLL_CP: begin
            if (ptr_q < ADDRW'(BUFFSIZE)) begin
               raddr_d = ptr_q;
               rd_d    = 1'b1;
               ptr_d   = ptr_q + 1'b1;
            end
            // vm_rdata now holds the cell read two edges ago; move it up one row.
            if (rd_data_q) begin
               we_d    = 1'b1;
               waddr_d = rd_addr_q - ADDRW'(TEXTCOL);
               wdata_d = bus.vm_rdata;
               if (rd_addr_q == LAST_CELL) begin
                  state_d = ST_SCROLL_CLR;
                  ptr_d   = LAST_ROW0;
               end
            end
         end
         ST_SCROLL_CLR: begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = FILL;
            if (ptr_q == LAST_CELL) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         raddr_q    <= '0;
         rd_q       <= 1'b0;
         rd_data_q  <= 1'b0;
         rd_addr_q  <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         raddr_q    <= raddr_d;
         rd_q       <= rd_d;
         rd_data_q  <= rd_q;
         rd_addr_q  <= raddr_q;
         in_ready_q <= in_ready_d;
         busy_q     <= ~in_ready_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.vm_we    = we_q;
   assign bus.vm_waddr = waddr_q;
   assign bus.vm_wdata = wdata_q;
   assign bus.vm_raddr = raddr_q;
   assign bus.cur_col  = cur_col;
   assign bus.cur_row  = cur_row;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_text_term_writer.sv
// tb/tb_text_term_writer.sv - self-checking bench for text_term_writer
module tb_text_term_writer;
   import ppu_pkg::*;

   typedef struct {
      logic [7:0] din;
      logic       we;
      int         addr;
      logic [7:0] wd;
      int         col;
      int         row;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   text_term_writer_if bus();

   text_term_writer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]  vram [0:4095];
   logic        pre_we   = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   int          bad_addr = 0;

   always @(posedge clk) begin
      if (pre_we) vram[pre_addr] <= pre_data;
      else if (bus.vm_we) vram[bus.vm_waddr] <= bus.vm_wdata;
      bus.vm_rdata <= vram[bus.vm_raddr];
      if (bus.vm_we && int'(bus.vm_waddr) >= BUFFSIZE) bad_addr <= bad_addr + 1;
   end

   int checks = 0;
   int errors = 0;

   logic [7:0] scr [BUFFSIZE];
   int         mc, mr;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_ready(output int lo);
      lo = 0;
      while (!bus.in_ready && lo < 3000) begin
         @(negedge clk);
         lo++;
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the byte is taken.
   task automatic send(input logic [7:0] b);
      int lo;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      wait_ready(lo);
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=0 expected 1 after %0d cycles", lo);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_clear(input string tag);
      int n = 0, seq = 0, rise = 0;
      for (int j = 1; j <= 2600; j++) begin
         @(negedge clk);
         if (bus.vm_we) begin
            if (int'(bus.vm_waddr) != n || bus.vm_wdata != FILL) seq++;
            n++;
         end
         if (bus.in_ready) begin
            rise = j;
            break;
         end
      end
      chk({tag, "_writes"}, n, BUFFSIZE);
      chk({tag, "_order"}, seq, 0);
      chk({tag, "_ready_cycle"}, rise, BUFFSIZE);
      chk({tag, "_col"}, int'(bus.cur_col), 0);
      chk({tag, "_row"}, int'(bus.cur_row), 0);
   endtask

   task automatic model_scroll();
      for (int i = 0; i < BUFFSIZE - TEXTCOL; i++) scr[i] = scr[i + TEXTCOL];
      for (int i = BUFFSIZE - TEXTCOL; i < BUFFSIZE; i++) scr[i] = FILL;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b >= 8'h20) begin
         scr[mr * TEXTCOL + mc] = b;
         mc++;
         if (mc == TEXTCOL) begin
            mc = 0;
            if (mr == TEXTROW - 1) model_scroll();
            else mr++;
         end
      end else if (b == CC_CR) begin
         mc = 0;
      end else if (b == CC_LF) begin
         mc = 0;
         if (mr == TEXTROW - 1) model_scroll();
         else mr++;
      end else if (b == CC_BS && (mc > 0 || mr > 0)) begin
         if (mc > 0) mc--;
         else begin
            mc = TEXTCOL - 1;
            mr--;
         end
         scr[mr * TEXTCOL + mc] = FILL;
      end
   endtask

   initial begin : main
      vec_t tbl [13];
      int   lo, ea, eb, ef, diff, r;
      logic [7:0] b;

      tbl[0]  = '{8'h78, 1'b1,  2, 8'h78,  3, 0};
      tbl[1]  = '{8'h0D, 1'b0,  0, 8'h00,  0, 0};
      tbl[2]  = '{8'h0A, 1'b0,  0, 8'h00,  0, 1};
      tbl[3]  = '{8'h61, 1'b1, 64, 8'h61,  1, 1};
      tbl[4]  = '{8'h08, 1'b1, 64, 8'h20,  0, 1};
      tbl[5]  = '{8'h08, 1'b1, 63, 8'h20, 63, 0};
      tbl[6]  = '{8'h08, 1'b1, 62, 8'h20, 62, 0};
      tbl[7]  = '{8'h01, 1'b0,  0, 8'h00, 62, 0};
      tbl[8]  = '{8'h0D, 1'b0,  0, 8'h00,  0, 0};
      tbl[9]  = '{8'h08, 1'b0,  0, 8'h00,  0, 0};
      tbl[10] = '{8'h7F, 1'b1,  0, 8'h7F,  1, 0};
      tbl[11] = '{8'hFF, 1'b1,  1, 8'hFF,  2, 0};
      tbl[12] = '{8'h1F, 1'b0,  0, 8'h00,  2, 0};

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_we", int'(bus.vm_we), 0);
      chk("rst_waddr", int'(bus.vm_waddr), 0);
      chk("rst_wdata", int'(bus.vm_wdata), 0);
      chk("rst_raddr", int'(bus.vm_raddr), 0);
      chk("rst_col", int'(bus.cur_col), 0);
      chk("rst_row", int'(bus.cur_row), 0);
      chk("rst_ready", int'(bus.in_ready), 0);
      chk("rst_busy", int'(bus.busy), 1);
      rst = 1'b0;
      wait_clear("reset_clear");
      chk("idle_busy", int'(bus.busy), 0);

      // "Hi" on consecutive cycles
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h48;
      @(negedge clk);
      chk("hi_we0", int'(bus.vm_we), 1);
      chk("hi_addr0", int'(bus.vm_waddr), 0);
      chk("hi_data0", int'(bus.vm_wdata), 8'h48);
      bus.in_data = 8'h69;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("hi_we1", int'(bus.vm_we), 1);
      chk("hi_addr1", int'(bus.vm_waddr), 1);
      chk("hi_data1", int'(bus.vm_wdata), 8'h69);
      chk("hi_col", int'(bus.cur_col), 2);
      chk("hi_row", int'(bus.cur_row), 0);

      for (int i = 0; i < 13; i++) begin
         send(tbl[i].din);
         chk($sformatf("vec%0d_we", i), int'(bus.vm_we), int'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("vec%0d_addr", i), int'(bus.vm_waddr), tbl[i].addr);
            chk($sformatf("vec%0d_data", i), int'(bus.vm_wdata), int'(tbl[i].wd));
         end
         chk($sformatf("vec%0d_col", i), int'(bus.cur_col), tbl[i].col);
         chk($sformatf("vec%0d_row", i), int'(bus.cur_row), tbl[i].row);
      end

      // Backspace from the start of row 3 wraps to the end of row 2
      send(CC_CR);
      repeat (3) send(CC_LF);
      send(CC_BS);
      chk("bs_we", int'(bus.vm_we), 1);
      chk("bs_addr", int'(bus.vm_waddr), 191);
      chk("bs_data", int'(bus.vm_wdata), FILL);
      chk("bs_col", int'(bus.cur_col), 63);
      chk("bs_row", int'(bus.cur_row), 2);

      send(CC_CR);
      repeat (3) send(CC_LF);
      repeat (63) send(8'h2E);
      send(8'h5A);
      chk("z_addr", int'(bus.vm_waddr), 383);
      chk("z_data", int'(bus.vm_wdata), 8'h5A);
      chk("z_col", int'(bus.cur_col), 0);
      chk("z_row", int'(bus.cur_row), 6);

      repeat (30) send(CC_LF);
      chk("lastrow_row", int'(bus.cur_row), 36);
      for (int i = 0; i < 2 * TEXTCOL; i++) begin
         pre_we   = 1'b1;
         pre_addr = (i < TEXTCOL) ? 12'(TEXTCOL + i) : 12'(2304 + i - TEXTCOL);
         pre_data = (i < TEXTCOL) ? 8'h41 : 8'h42;
         @(negedge clk);
      end
      pre_we = 1'b0;
      send(CC_LF);
      chk("scroll_ready_low", int'(bus.in_ready), 0);
      chk("scroll_busy", int'(bus.busy), 1);
      wait_ready(lo);
      chk("scroll_low_cycles", lo, 2305 + 64);
      @(negedge clk);
      ea = 0; eb = 0; ef = 0;
      for (int i = 0; i < TEXTCOL; i++) begin
         if (vram[i] != 8'h41) ea++;
         if (vram[2240 + i] != 8'h42) eb++;
         if (vram[2304 + i] != FILL) ef++;
      end
      chk("scroll_row0_A", ea, 0);
      chk("scroll_row35_B", eb, 0);
      chk("scroll_row36_fill", ef, 0);
      chk("scroll_col", int'(bus.cur_col), 0);
      chk("scroll_row", int'(bus.cur_row), 36);

      send(CC_LF);
      repeat (1000) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midscroll_rst_we", int'(bus.vm_we), 0);
      chk("midscroll_rst_busy", int'(bus.busy), 1);
      rst = 1'b0;
      wait_clear("midscroll_clear");

      send(CC_FF);
      chk("ff_no_write", int'(bus.vm_we), 0);
      chk("ff_ready_low", int'(bus.in_ready), 0);
      wait_clear("ff_clear");

      // Random byte stream against a character-grid model
      for (int i = 0; i < BUFFSIZE; i++) scr[i] = FILL;
      mc = 0;
      mr = 0;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 72)      b = 8'($urandom_range(32, 255));
         else if (r < 84) b = CC_LF;
         else if (r < 92) b = CC_BS;
         else if (r < 96) b = CC_CR;
         else begin
            b = 8'($urandom_range(0, 31));
            if (b == CC_FF) b = 8'h00;
         end
         model_byte(b);
         send(b);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      wait_ready(lo);
      chk("rand_final_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      diff = 0;
      for (int i = 0; i < BUFFSIZE; i++) if (vram[i] != scr[i]) diff++;
      chk("rand_screen_cells", diff, 0);
      chk("rand_col", int'(bus.cur_col), mc);
      chk("rand_row", int'(bus.cur_row), mr);
      chk("write_addr_range", bad_addr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
